mem_dma_master: RTL
===================

# mem_dma_master

Bus-master DMA engine that drives the data-memory bus (`Address`/`Write_data`/`MemRead`/`MemWrite`/`Mem_data`) as initiator. It sits beside the CPU datapath behind a one-bit request/grant arbiter. It copies a block of words from `src_addr` to `dst_addr`, or fills a block with a constant. MMIO addresses (LED `0x4000000C`, digit `0x40000010`) are legal targets.

## Interface
- `LEN_W`, default 10: width of the word-count input (max 1023 words).
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle launch strobe; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; latched at start.
- `src_addr`  in  32  source byte address (copy); latched at start.
- `dst_addr`  in  32  destination byte address; latched at start.
- `len_words`  in  LEN_W  number of words; latched at start.
- `fill_data`  in  32  fill value; latched at start.
- `busy`  out  1  high from the cycle after an accepted start until DONE is left.
- `done`  out  1  one-cycle pulse at transfer end, including error and zero-length ends.
- `err`  out  1  sticky misalignment flag; cleared by the next accepted start.
- `bus_req`  out  1  bus request to arbiter.
- `bus_gnt`  in  1  bus grant from arbiter.
- `Address`  out  32  bus address.
- `Write_data`  out  32  bus write data.
- `MemRead`  out  1  read strobe; memory read data is combinational.
- `MemWrite`  out  1  write strobe; memory commits on the rising edge.
- `Mem_data`  in  32  read data from memory.

## Operation
- States: IDLE, REQ, RD, WR, DONE.
- **IDLE:**
  - On `start`, latch all inputs and clear `err`.
  - If `src_addr[1:0]` ≠ 0 (copy mode only) or `dst_addr[1:0]` ≠ 0: set `err`, go to DONE.
  - Else if `len_words` = 0: go to DONE.
  - Else go to REQ.
- **REQ:** `bus_req` = 1. If `bus_gnt`, go to RD (copy) or WR (fill).
- **RD:**
  - While `bus_gnt` is high: `MemRead` = 1, `Address` = current src.
  - At the edge, capture `Mem_data` into the word buffer, add 4 to src, go to WR.
- **WR:**
  - While `bus_gnt` is high: `MemWrite` = 1, `Address` = current dst, `Write_data` = buffer (copy) or `fill_data` (fill).
  - At the edge, add 4 to dst and decrement the remaining count.
  - If the count reaches 0, go to DONE. Else go to RD (copy) or stay in WR (fill).
- **DONE:** `done` = 1 for one cycle, `bus_req` = 0, go to IDLE.
- **Grant loss:** if `bus_gnt` is low in RD or WR, hold state, counters and buffer. Strobes are low; `bus_req` stays high. Resume when grant returns.
- **Idle bus outputs:** when not strobing, `Address`/`Write_data` = 0.
- **Address arithmetic:** 32-bit, wraps modulo 2^32. No range check; out-of-range handling is the memory's job.
- **Ignored starts:** `start` while busy is ignored, with no effect on latched values.
- **Reset:**
  - All outputs low/zero; state IDLE; `err` = 0.
  - Reset mid-transfer aborts immediately. Words already written stay written. No `done` pulse.

## Timing
- With `bus_gnt` held high and start accepted at edge E0:
  - Copy of N words: REQ in cycle 1, RD/WR alternate over cycles 2..2N+1, `done` high in cycle 2N+2.
  - Fill of N words: `done` high in cycle N+2.
- Error and zero-length: `done` in cycle 1, no bus access, `bus_req` never asserted.
- Strobes are combinational from state and `bus_gnt`. `Address` and `Write_data` are valid in the same cycle as their strobe.
- Read data is sampled at the RD-cycle edge; no wait states are assumed beyond grant.
- Throughput: 0.5 word/cycle for copy, 1 word/cycle for fill.

## Structure
- Shared package `mem_bus_pkg`:
  - state enum;
  - `WORD_BYTES` = 4;
  - MMIO constants: `MMIO_LED` = `32'h4000000C`, `MMIO_DIGI` = `32'h40000010`, `MMIO_REGION` = `4'h4`.
- Single module; no sub-module warranted. Counters and buffer live inline.

## Test plan
- **Copy:** preload RAM words 0x0F..0x12 = {0x0A, 0x0A, 0x02, 0x0C}; copy src `0x3C` → dst `0x100`, len 4, gnt tied high. Expect:
  - RAM[0x40..0x43] = {0x0A, 0x0A, 0x02, 0x0C};
  - `done` pulse exactly 10 cycles after the start edge;
  - `busy` high for cycles 1..10.
- **Fill into MMIO:** fill dst `0x4000000C`, len 1, `fill_data` `0xA5`. Expect `led` = `0xA5`, `done` at cycle 3.
- **Grant stall:** copy len 2, `bus_gnt` dropped for 3 cycles during the first WR. Expect:
  - no strobes while gnt is low;
  - destination data correct;
  - `done` delayed by exactly 3 cycles.
- **Misaligned:** `src_addr` = `0x102`, copy. Expect `err` = 1, `done` at cycle 1, `bus_req` never high, RAM unchanged. A following valid start clears `err`.
- **Zero length and busy start:** `len_words` = 0 gives `done` at cycle 1 with no bus activity. A `start` pulsed mid-copy is ignored: latched length unchanged, a single `done`.
- **Reset abort:** assert `reset` low after the 2nd WR of a 4-word copy. Expect:
  - outputs zero immediately;
  - first 2 destination words written, last 2 untouched;
  - no `done` pulse.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for initiators of the data-memory bus.
//   dma_state_t  - DMA master FSM states (also exported on the debug port)
//   WORD_BYTES   - byte stride between consecutive bus words
//   MMIO_*       - memory-mapped peripheral addresses reachable over the bus
package mem_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } dma_state_t;

    localparam logic [31:0] WORD_BYTES  = 32'd4;

    localparam logic [31:0] MMIO_LED    = 32'h4000000C;
    localparam logic [31:0] MMIO_DIGI   = 32'h40000010;
    localparam logic [3:0]  MMIO_REGION = 4'h4;

endpackage

// File: rtl/mem_dma_master.sv
// mem_dma_master: bus-master DMA engine for the data-memory bus.
// Copies len_words words from src_addr to dst_addr (mode 0) or fills
// len_words words at dst_addr with fill_data (mode 1).
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 one-cycle launch strobe, sampled only in IDLE
//   mode, src_addr, dst_addr, len_words, fill_data
//                         transfer descriptor, latched when start is accepted
//   busy                  high from the cycle after an accepted start until DONE is left
//   done                  one-cycle pulse at every transfer end (error / zero length too)
//   err                   sticky misalignment flag, cleared by the next accepted start
//   bus_req, bus_gnt      arbiter request / grant
//   Address, Write_data,
//   MemRead, MemWrite     bus outputs; Address/Write_data are zero when not strobing
//   Mem_data              combinational read data from memory
//   dbg_state             current FSM state, for observation only
//
// Bus handshake: bus_req is held high from REQ through the last WR. A bus
// cycle happens only in a cycle where the FSM is in RD/WR and bus_gnt is high;
// the strobe, Address and Write_data are valid together in that cycle and the
// transfer completes at the following rising edge. With bus_gnt low the engine
// freezes (no strobe, all counters/buffer held) and resumes when grant returns.
module mem_dma_master
    import mem_bus_pkg::*;
#(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      Address,
    output logic [31:0]      Write_data,
    output logic             MemRead,
    output logic             MemWrite,
    input  logic [31:0]      Mem_data,
    output dma_state_t       dbg_state
);

    dma_state_t       state_q, state_d;
    logic             mode_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;
    logic [31:0]      fill_q;
    logic [31:0]      buf_q;
    logic             err_q;

    // Alignment is judged on the live inputs so the decision is made in the
    // same edge that accepts the start; the source only matters for copies.
    logic misaligned;
    assign misaligned = ((mode == 1'b0) && (src_addr[1:0] != 2'b00)) ||
                        (dst_addr[1:0] != 2'b00);

    assign err       = err_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start) begin
                mode_q <= mode;
                src_q  <= src_addr;
                dst_q  <= dst_addr;
                cnt_q  <= len_words;
                fill_q <= fill_data;
                err_q  <= misaligned;
            end
            if ((state_q == S_RD) && bus_gnt) begin
                buf_q <= Mem_data;
                src_q <= src_q + WORD_BYTES;
            end
            if ((state_q == S_WR) && bus_gnt) begin
                dst_q <= dst_q + WORD_BYTES;
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        bus_req    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (misaligned || (len_words == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = mode_q ? S_WR : S_RD;
                end
            end
            S_RD: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    MemRead = 1'b1;
                    Address = src_q;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    MemWrite   = 1'b1;
                    Address    = dst_q;
                    Write_data = mode_q ? fill_q : buf_q;
                    // cnt_q still holds the pre-decrement count here.
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = mode_q ? S_WR : S_RD;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
